// File: rtl/tlb_assoc_array_if.sv
// Lookup, refill and flush signal bundle between the TLB controller (master) and tlb_assoc_array (slave).
// ASID signals are present only when TLB_ASID_EN is defined.
interface tlb_assoc_array_if #(
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4,
    parameter int VPN_BITS  = 20,
    parameter int PPN_BITS  = 20,
    parameter int PERM_BITS = 2,
    parameter int ASID_BITS = 8
);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    logic                 lk_valid;
    logic                 lk_ready;
    logic [VPN_BITS-1:0]  lk_vpn;
    logic                 lk_resp_valid;
    logic                 lk_hit;
    logic [WAY_BITS-1:0]  lk_way;
    logic [PPN_BITS-1:0]  lk_ppn;
    logic [PERM_BITS-1:0] lk_perms;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [SET_BITS-1:0]  wr_set;
    logic [WAY_BITS-1:0]  wr_way;
    logic [VPN_BITS-1:0]  wr_vpn;
    logic [PPN_BITS-1:0]  wr_ppn;
    logic [PERM_BITS-1:0] wr_perms;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;
`ifdef TLB_ASID_EN
    logic [ASID_BITS-1:0] lk_asid;
    logic [ASID_BITS-1:0] wr_asid;
    logic                 flush_asid_en;
    logic [ASID_BITS-1:0] flush_asid;

    modport master (
        output lk_valid, lk_vpn, wr_valid, wr_set, wr_way, wr_vpn, wr_ppn, wr_perms,
               flush_req, lk_asid, wr_asid, flush_asid_en, flush_asid,
        input  lk_ready, lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, wr_ready,
               flush_busy, flush_done
    );
    modport slave (
        input  lk_valid, lk_vpn, wr_valid, wr_set, wr_way, wr_vpn, wr_ppn, wr_perms,
               flush_req, lk_asid, wr_asid, flush_asid_en, flush_asid,
        output lk_ready, lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, wr_ready,
               flush_busy, flush_done
    );
`else
    modport master (
        output lk_valid, lk_vpn, wr_valid, wr_set, wr_way, wr_vpn, wr_ppn, wr_perms, flush_req,
        input  lk_ready, lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, wr_ready,
               flush_busy, flush_done
    );
    modport slave (
        input  lk_valid, lk_vpn, wr_valid, wr_set, wr_way, wr_vpn, wr_ppn, wr_perms, flush_req,
        output lk_ready, lk_resp_valid, lk_hit, lk_way, lk_ppn, lk_perms, wr_ready,
               flush_busy, flush_done
    );
`endif
endinterface

// File: rtl/tlb_assoc_array.sv
// Set-associative TLB array: registered VPN lookup, LRU aging, victim choice and a one-set-per-cycle flush sweep.
// Optional feature macro TLB_ASID_EN: per-entry ASID tag and ASID-selective flush.
module tlb_assoc_array #(
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4,
    parameter int VPN_BITS  = 20,
    parameter int PPN_BITS  = 20,
    parameter int PERM_BITS = 2,
    parameter int LRU_BITS  = 4,
    parameter int ASID_BITS = 8
) (
    input logic              clk,
    input logic              rst,
    tlb_assoc_array_if.slave bus
);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam logic [LRU_BITS-1:0] LRU_MAX = '1;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_reg, state_next;
    logic [SET_BITS-1:0] sweep_cnt_reg, sweep_cnt_next;
    logic                flush_busy;

    logic [NUM_WAYS-1:0]  valid_reg [NUM_SETS];
    logic [LRU_BITS-1:0]  lru_reg   [NUM_SETS][NUM_WAYS];
    logic [VPN_BITS-1:0]  tag_reg   [NUM_SETS][NUM_WAYS];
    logic [PPN_BITS-1:0]  ppn_reg   [NUM_SETS][NUM_WAYS];
    logic [PERM_BITS-1:0] perms_reg [NUM_SETS][NUM_WAYS];

    logic                 lk_resp_valid_reg, lk_hit_reg;
    logic [WAY_BITS-1:0]  lk_way_reg;
    logic [PPN_BITS-1:0]  lk_ppn_reg;
    logic [PERM_BITS-1:0] lk_perms_reg;
    logic                 touch_pending_reg;
    logic [SET_BITS-1:0]  touch_set_reg;
    logic [WAY_BITS-1:0]  touch_way_reg;

    logic                lk_fire, wr_fire, touch_en;
    logic [SET_BITS-1:0] lk_set;
    logic [NUM_WAYS-1:0] set_valid, asid_ok, way_match, flush_match;
    logic                hit_any;
    logic [WAY_BITS-1:0] hit_way, victim_way;
    logic [LRU_BITS-1:0] best_lru, touch_old_lru;

    function automatic logic [LRU_BITS-1:0] sat_inc(input logic [LRU_BITS-1:0] v);
        return (v == LRU_MAX) ? v : v + 1'b1;
    endfunction

    assign flush_busy    = (state_reg == SWEEP);
    assign lk_fire       = bus.lk_valid && !flush_busy;
    assign wr_fire       = bus.wr_valid && !flush_busy;
    assign lk_set        = bus.lk_vpn[SET_BITS-1:0];
    assign set_valid     = valid_reg[lk_set];
    assign touch_old_lru = lru_reg[touch_set_reg][touch_way_reg];
    // A refill into the touched set takes precedence; that set's touch is dropped.
    assign touch_en      = touch_pending_reg && !flush_busy &&
                           !(wr_fire && (bus.wr_set == touch_set_reg));

`ifdef TLB_ASID_EN
    logic [ASID_BITS-1:0] asid_reg [NUM_SETS][NUM_WAYS];
    logic                 flush_sel_reg;
    logic [ASID_BITS-1:0] flush_asid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_sel_reg  <= 1'b0;
            flush_asid_reg <= '0;
        end else if (state_reg == IDLE && bus.flush_req) begin
            flush_sel_reg  <= bus.flush_asid_en;
            flush_asid_reg <= bus.flush_asid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) asid_reg[bus.wr_set][bus.wr_way] <= bus.wr_asid;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
`ifdef TLB_ASID_EN
            assign asid_ok[gi]     = (asid_reg[lk_set][gi] == bus.lk_asid);
            assign flush_match[gi] = !flush_sel_reg || (asid_reg[sweep_cnt_reg][gi] == flush_asid_reg);
`else
            assign asid_ok[gi]     = 1'b1;
            assign flush_match[gi] = 1'b1;
`endif
            assign way_match[gi] = set_valid[gi] && asid_ok[gi] && (tag_reg[lk_set][gi] == bus.lk_vpn);
        end
    endgenerate

    // Hit: lowest matching way. Victim: lowest invalid way, else oldest (ties to lowest index).
    always_comb begin
        hit_any    = |way_match;
        hit_way    = '0;
        victim_way = '0;
        best_lru   = lru_reg[lk_set][0];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) hit_way = WAY_BITS'(w);
        end
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (lru_reg[lk_set][w] > best_lru) begin
                best_lru   = lru_reg[lk_set][w];
                victim_way = WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim_way = WAY_BITS'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_resp_valid_reg <= 1'b0;
            lk_hit_reg        <= 1'b0;
            lk_way_reg        <= '0;
            lk_ppn_reg        <= '0;
            lk_perms_reg      <= '0;
            touch_pending_reg <= 1'b0;
            touch_set_reg     <= '0;
            touch_way_reg     <= '0;
        end else begin
            lk_resp_valid_reg <= lk_fire;
            touch_pending_reg <= lk_fire && hit_any;
            if (lk_fire) begin
                lk_hit_reg    <= hit_any;
                lk_way_reg    <= hit_any ? hit_way : victim_way;
                lk_ppn_reg    <= hit_any ? ppn_reg[lk_set][hit_way] : '0;
                lk_perms_reg  <= hit_any ? perms_reg[lk_set][hit_way] : '0;
                touch_set_reg <= lk_set;
                touch_way_reg <= hit_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) lru_reg[s][w] <= '0;
            end
        end else if (flush_busy) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (flush_match[w]) begin
                    valid_reg[sweep_cnt_reg][w] <= 1'b0;
                    lru_reg[sweep_cnt_reg][w]   <= '0;
                end
            end
        end else begin
            if (touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_BITS'(w) == touch_way_reg)
                        lru_reg[touch_set_reg][w] <= '0;
                    else if (valid_reg[touch_set_reg][w] && lru_reg[touch_set_reg][w] < touch_old_lru)
                        lru_reg[touch_set_reg][w] <= sat_inc(lru_reg[touch_set_reg][w]);
                end
            end
            if (wr_fire) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_BITS'(w) == bus.wr_way) begin
                        valid_reg[bus.wr_set][w] <= 1'b1;
                        lru_reg[bus.wr_set][w]   <= '0;
                    end else if (valid_reg[bus.wr_set][w]) begin
                        lru_reg[bus.wr_set][w] <= sat_inc(lru_reg[bus.wr_set][w]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            tag_reg[bus.wr_set][bus.wr_way]   <= bus.wr_vpn;
            ppn_reg[bus.wr_set][bus.wr_way]   <= bus.wr_ppn;
            perms_reg[bus.wr_set][bus.wr_way] <= bus.wr_perms;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.flush_req) begin
                    state_next     = SWEEP;
                    sweep_cnt_next = '0;
                end
            end
            SWEEP: begin
                if (sweep_cnt_reg == LAST_SET) begin
                    state_next     = IDLE;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.lk_ready      = !flush_busy;
    assign bus.wr_ready      = !flush_busy;
    assign bus.flush_busy    = flush_busy;
    assign bus.flush_done    = flush_busy && (sweep_cnt_reg == LAST_SET);
    assign bus.lk_resp_valid = lk_resp_valid_reg;
    assign bus.lk_hit        = lk_hit_reg;
    assign bus.lk_way        = lk_way_reg;
    assign bus.lk_ppn        = lk_ppn_reg;
    assign bus.lk_perms      = lk_perms_reg;
endmodule
